// File: rtl/pi_ctl_regs.sv
// SPI-mapped control register file: register 0 drives 6502 reset/ready with a timed reset pulse
// and single-step sequencer; registers 1..N_REGS-1 are plain control bytes. Read-back is built only when PI_CTL_READBACK_EN is defined.
module pi_ctl_regs #(
    parameter logic [16:0] BASE_ADDR    = 17'h0E80F,
    parameter int          N_REGS       = 4,
    parameter int          RESET_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  spi_rw_n_i,
    input  logic [16:0]           spi_addr_i,
    input  logic [7:0]            spi_data_i,
    input  logic                  spi_enable_i,
    output logic [7:0]            spi_data_o,
    output logic                  spi_valid_o,
    input  logic                  cpu_clk_en_i,
    output logic                  cpu_res_no,
    output logic                  cpu_ready_o,
    output logic [N_REGS*8-1:0]   ctl_o
);

    localparam int CW = $clog2(RESET_CYCLES + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ARMED = 1'b1;

    logic [16:0]   w_offset;
    logic          w_hit;
    logic          w_wr;
    logic          w_wr0;
    logic          w_pulse_busy;
    logic          w_step_busy;
    logic [7:0]    w_reg0_view;
    logic [7:0]    r_regs [N_REGS];
    logic [CW-1:0] r_pulse_cnt;
    logic [0:0]    r_state;

    // Wrapping subtraction makes addresses below BASE_ADDR land far outside the window.
    assign w_offset = spi_addr_i - BASE_ADDR;
    assign w_hit    = (w_offset < 17'(N_REGS));
    assign w_wr     = spi_enable_i & ~spi_rw_n_i & w_hit;
    assign w_wr0    = w_wr & (w_offset == 17'd0);

    // Register 0 keeps only RES_N/READY; STEP and PULSE act as strobes and never stick.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int k = 0; k < N_REGS; k++) begin
                r_regs[k] <= 8'h00;
            end
        end else begin
            for (int k = 0; k < N_REGS; k++) begin
                if (w_wr && (w_offset == 17'(k))) begin
                    r_regs[k] <= (k == 0) ? {6'b000000, spi_data_i[1:0]} : spi_data_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_pulse_cnt <= '0;
        end else if (w_wr0 && spi_data_i[3]) begin
            r_pulse_cnt <= CW'(RESET_CYCLES);
        end else if (r_pulse_cnt != '0) begin
            r_pulse_cnt <= r_pulse_cnt - CW'(1);
        end
    end

    // A strobe coincident with the arming write is ignored because the FSM is still IDLE then.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else if (w_wr0 && spi_data_i[3]) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr0 && spi_data_i[2] && !spi_data_i[1]) begin
                        r_state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (cpu_clk_en_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_pulse_busy = (r_pulse_cnt != '0);
    assign w_step_busy  = (r_state == S_ARMED);
    assign w_reg0_view  = r_regs[0] | {2'b00, w_pulse_busy, w_step_busy, 4'b0000};
    assign cpu_res_no   = r_regs[0][0] & ~w_pulse_busy;
    assign cpu_ready_o  = r_regs[0][1] | w_step_busy;

    genvar gi;
    generate
        for (gi = 0; gi < N_REGS; gi++) begin : g_ctl
            if (gi == 0) begin : g_reg0
                assign ctl_o[7:0] = w_reg0_view;
            end else begin : g_gp
                assign ctl_o[8*gi +: 8] = r_regs[gi];
            end
        end
    endgenerate

`ifdef PI_CTL_READBACK_EN
    logic       w_rd;
    logic [7:0] w_rd_data;
    logic [7:0] r_spi_data;
    logic       r_spi_valid;

    assign w_rd = spi_enable_i & spi_rw_n_i & w_hit;

    always_comb begin
        w_rd_data = 8'h00;
        for (int k = 0; k < N_REGS; k++) begin
            if (w_offset == 17'(k)) begin
                w_rd_data = (k == 0) ? w_reg0_view : r_regs[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_spi_data  <= 8'h00;
            r_spi_valid <= 1'b0;
        end else begin
            r_spi_valid <= w_rd;
            if (w_rd) begin
                r_spi_data <= w_rd_data;
            end
        end
    end

    assign spi_data_o  = r_spi_data;
    assign spi_valid_o = r_spi_valid;
`else
    assign spi_data_o  = 8'h00;
    assign spi_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_pi_ctl_regs.sv
// Self-checking bench for pi_ctl_regs: directed test-plan sequences plus random SPI traffic,
// compared every cycle against a time-based behavioural model.
module tb_pi_ctl_regs;

    localparam logic [16:0] BASE = 17'h0E80F;
    localparam int          NR   = 4;
    localparam int          RC   = 16;

    logic            clk = 1'b0;
    logic            reset_i;
    logic            spi_rw_n_i;
    logic [16:0]     spi_addr_i;
    logic [7:0]      spi_data_i;
    logic            spi_enable_i;
    logic [7:0]      spi_data_o;
    logic            spi_valid_o;
    logic            cpu_clk_en_i;
    logic            cpu_res_no;
    logic            cpu_ready_o;
    logic [NR*8-1:0] ctl_o;

    always #5 clk = ~clk;

    pi_ctl_regs #(.BASE_ADDR(BASE), .N_REGS(NR), .RESET_CYCLES(RC)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .spi_rw_n_i   (spi_rw_n_i),
        .spi_addr_i   (spi_addr_i),
        .spi_data_i   (spi_data_i),
        .spi_enable_i (spi_enable_i),
        .spi_data_o   (spi_data_o),
        .spi_valid_o  (spi_valid_o),
        .cpu_clk_en_i (cpu_clk_en_i),
        .cpu_res_no   (cpu_res_no),
        .cpu_ready_o  (cpu_ready_o),
        .ctl_o        (ctl_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: pulse is an end-time, step is a flag, registers are plain bytes.
    bit         m_res_n, m_ready, m_armed;
    logic [7:0] m_gp [NR];
    longint     cyc = 0;
    longint     pulse_end = 0;
    logic [7:0] m_rdata = 8'h00;
    bit         m_rvalid = 1'b0;
    bit         ready_at_edge;

    function automatic logic [7:0] m_reg0();
        return {2'b00, (cyc < pulse_end), m_armed, 2'b00, m_ready, m_res_n};
    endfunction

    task automatic cyc_t(input bit rst, input bit en, input bit rw,
                         input logic [16:0] a, input logic [7:0] d, input bit ce);
        logic [16:0]     off;
        bit              hit, armed_pre;
        logic [NR*8-1:0] e_ctl;
        reset_i = rst; spi_enable_i = en; spi_rw_n_i = rw;
        spi_addr_i = a; spi_data_i = d; cpu_clk_en_i = ce;
        ready_at_edge = cpu_ready_o;
        @(posedge clk);
        off = a - BASE;
        hit = (off < 17'(NR));
        if (rst) begin
            m_res_n = 0; m_ready = 0; m_armed = 0; pulse_end = 0;
            for (int k = 0; k < NR; k++) m_gp[k] = 8'h00;
            m_rdata = 8'h00; m_rvalid = 0;
        end else begin
            armed_pre = m_armed;
            m_rvalid = 0;
`ifdef PI_CTL_READBACK_EN
            if (en && rw && hit) begin
                m_rvalid = 1;
                m_rdata = (off == 0) ? m_reg0() : m_gp[off];
            end
`endif
            if (armed_pre && ce) m_armed = 0;
            if (en && !rw && hit) begin
                if (off == 0) begin
                    m_res_n = d[0];
                    m_ready = d[1];
                    if (d[3]) begin
                        pulse_end = cyc + 1 + RC;
                        m_armed = 0;
                    end else if (!armed_pre && d[2] && !d[1]) begin
                        m_armed = 1;
                    end
                end else begin
                    m_gp[off] = d;
                end
            end
        end
        cyc++;
        #1;
        for (int k = 0; k < NR; k++) e_ctl[8*k +: 8] = (k == 0) ? m_reg0() : m_gp[k];
        chk("res_n", 32'(cpu_res_no), 32'(m_res_n && !(cyc < pulse_end)));
        chk("ready", 32'(cpu_ready_o), 32'(m_ready || m_armed));
        chk("ctl", 32'(ctl_o), 32'(e_ctl));
        chk("valid", 32'(spi_valid_o), 32'(m_rvalid));
        chk("rdata", 32'(spi_data_o), 32'(m_rdata));
    endtask

    task automatic wr(input logic [16:0] a, input logic [7:0] d);
        cyc_t(0, 1, 0, a, d, 0);
    endtask

    task automatic idle(input bit ce);
        cyc_t(0, 0, 1, BASE, 8'h00, ce);
    endtask

    initial begin
        int lowcnt, strobes;
        logic [16:0] a;
        logic [7:0]  d;

        for (int i = 0; i < 3; i++) cyc_t(1, 0, 0, BASE, 8'h00, 0);
        chk("rst_res_n", 32'(cpu_res_no), 32'd0);
        chk("rst_ready", 32'(cpu_ready_o), 32'd0);

        wr(BASE, 8'h03);
        chk("rdy_up_res", 32'(cpu_res_no), 32'd1);
        chk("rdy_up_ready", 32'(cpu_ready_o), 32'd1);

        // Single pulse: low exactly RC cycles.
        lowcnt = 0;
        wr(BASE, 8'h09);
        if (!cpu_res_no) lowcnt++;
        for (int i = 1; i < 40; i++) begin
            idle(0);
            if (!cpu_res_no) lowcnt++;
        end
        chk("pulse_len", 32'(lowcnt), 32'(RC));

        // Restart at cycle 10 extends the low time.
        lowcnt = 0;
        wr(BASE, 8'h09);
        if (!cpu_res_no) lowcnt++;
        for (int i = 1; i < 40; i++) begin
            if (i == 10) wr(BASE, 8'h09); else idle(0);
            if (!cpu_res_no) lowcnt++;
        end
        chk("pulse_restart_len", 32'(lowcnt), 32'(RC + 10));

        // Step with a strobe coinciding with the arming write, then further strobes.
        strobes = 0;
        cyc_t(0, 1, 0, BASE, 8'h05, 1);
        for (int i = 0; i < 12; i++) begin
            if (i == 2) wr(BASE, 8'h05);
            else if (i == 3) wr(BASE, 8'h05);
            else begin
                idle(i >= 5);
                if ((i >= 5) && ready_at_edge) strobes++;
            end
        end
        chk("step_strobes", 32'(strobes), 32'd1);

        wr(BASE, 8'h07);
        chk("step_ignored_busy", 32'(ctl_o[4]), 32'd0);

        wr(BASE + 17'd3, 8'hA5);
        chk("gp3", 32'(ctl_o[31:24]), 32'hA5);
        wr(BASE + 17'd4, 8'h11);
        wr(BASE - 17'd1, 8'h22);
        cyc_t(0, 1, 1, BASE + 17'd3, 8'h00, 0);
        cyc_t(0, 1, 1, BASE + 17'd4, 8'h00, 0);
        cyc_t(0, 1, 1, BASE - 17'd1, 8'h00, 0);
        idle(0);

        for (int i = 0; i < 3000; i++) begin
            a = BASE + 17'($urandom_range(0, NR + 1)) - 17'd1;
            if ($urandom_range(0, 15) == 0) a = 17'($urandom);
            d = 8'($urandom);
            if ($urandom_range(0, 7) != 0) d[3] = 1'b0;
            cyc_t($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, a, d, $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pi_ctl_regs.md
# pi_ctl_regs

Parametrised SPI-mapped control register file that replaces the single fixed two-bit CPU control latch. It decodes SPI bus writes and reads to a window of `N_REGS` byte registers starting at `BASE_ADDR`. Register 0 drives 6502 reset and ready, and adds a timed reset pulse and a single-step sequencer. The remaining registers are general-purpose control outputs for the rest of the PET clone.

## Interface
Parameters:
- `BASE_ADDR`, 17'h0E80F, SPI address of register 0; register k is at `BASE_ADDR + k`.
- `N_REGS`, 4, number of byte registers, range 1..16.
- `RESET_CYCLES`, 16, duration of the reset pulse in `clk_i` cycles, range ≥ 1.

Ports:
- `clk_i`  in  1  system clock. One clock domain only.
- `reset_i`  in  1  reset. Synchronous, active-high.
- `spi_rw_n_i`  in  1  1 = read, 0 = write.
- `spi_addr_i`  in  17  SPI bus address.
- `spi_data_i`  in  8  write data.
- `spi_enable_i`  in  1  one-cycle transaction strobe.
- `spi_data_o`  out  8  read data.
- `spi_valid_o`  out  1  one-cycle read-data-valid strobe.
- `cpu_clk_en_i`  in  1  one-cycle strobe at the end of each CPU bus cycle.
- `cpu_res_no`  out  1  CPU reset, active-low.
- `cpu_ready_o`  out  1  CPU RDY.
- `ctl_o`  out  `N_REGS*8`  all register contents; register k is on `ctl_o[8k+7:8k]`.

## Operation
Address decode:
- A register is hit when `spi_addr_i - BASE_ADDR` is in `0..N_REGS-1`, computed as 17-bit unsigned arithmetic.
- Transactions to any other address are ignored and produce no `spi_valid_o`.

Register 0 bits:
- bit0 RES_N: static reset level.
- bit1 READY: static ready level.
- bit2 STEP: write-1 requests a single step. Self-clears.
- bit3 PULSE: write-1 starts a reset pulse. Self-clears.
- bit4 STEP_BUSY: read-only.
- bit5 PULSE_BUSY: read-only.
- bits7:6: read as 0.

Registers 1..N_REGS-1: plain read/write bytes, reflected on `ctl_o`.

Reset pulse:
- Writing PULSE = 1 loads the pulse counter with `RESET_CYCLES`.
- While the counter is non-zero: `cpu_res_no` = 0 and PULSE_BUSY = 1.
- When the counter reaches zero, `cpu_res_no` returns to RES_N.
- Writing PULSE = 1 again during a pulse reloads the counter (restart).
- Counter width is `$clog2(RESET_CYCLES+1)`.

Step FSM, states IDLE and ARMED:
- IDLE -> ARMED when reg0 is written with STEP = 1 and the written READY bit is 0.
- In ARMED, `cpu_ready_o` is forced to 1 and STEP_BUSY = 1.
- ARMED -> IDLE on the first `cpu_clk_en_i` pulse seen while in ARMED. Exactly one CPU cycle completes.
- STEP = 1 written with READY = 1 is ignored.
- STEP = 1 written while already ARMED does not extend or re-arm the step.
- A reg0 write in ARMED still updates RES_N and READY.
- A PULSE write in ARMED forces the FSM to IDLE.

Output equations:
- `cpu_res_no` = RES_N & (pulse counter == 0).
- `cpu_ready_o` = READY | (state == ARMED).

## Timing
- Writes take effect on the clock edge at which `spi_enable_i` is sampled high; outputs change on that same edge.
- Reads: `spi_data_o` and `spi_valid_o` are registered, valid exactly 1 cycle after the enable cycle. `spi_valid_o` is high for one cycle. `spi_data_o` holds its value until the next read.
- `cpu_clk_en_i` arriving in the same cycle as the arming write does not complete the step. The step needs a later strobe.
- `reset_i` has priority over everything. On reset:
  - all registers = 0
  - FSM = IDLE
  - pulse counter = 0
  - `cpu_res_no` = 0 (CPU held in reset until software sets RES_N)
  - `cpu_ready_o` = 0
  - `spi_data_o` = 0, `spi_valid_o` = 0
  - `ctl_o` = 0
- Reset asserted mid-pulse or mid-step aborts it immediately.

## Configuration
- `PI_CTL_READBACK_EN` defined:
  - Reads return register contents, with STEP and PULSE reading 0 and status bits live.
  - `spi_valid_o` behaves as specified above.
- `PI_CTL_READBACK_EN` undefined:
  - No read mux or data register is built.
  - `spi_data_o` is constant 0 and `spi_valid_o` is constant 0.
  - Write behaviour is unchanged.

## Test plan
- Reset, then write 0x03 to `BASE_ADDR` -> `cpu_res_no` = 1 and `cpu_ready_o` = 1 on the next cycle. Before the write, both are 0.
- With RES_N = 1, write 0x09 to reg0 -> `cpu_res_no` = 0 for exactly 16 cycles, then 1. PULSE_BUSY reads 1 during the pulse. A second 0x09 write at cycle 10 extends the low time to 26 cycles total.
- Write 0x05 to reg0 (READY = 0, STEP = 1) -> `cpu_ready_o` = 1 until the first subsequent `cpu_clk_en_i`, then 0. Exactly one strobe is seen with ready high.
- Write 0x07 to reg0 -> no ARMED state and STEP_BUSY = 0. Write 0x05 twice while ARMED -> a single step only.
- Write 0xA5 to `BASE_ADDR+3` -> `ctl_o[31:24]` = 0xA5. Writes to `BASE_ADDR+4` and `BASE_ADDR-1` -> no change and no `spi_valid_o`.
- With `PI_CTL_READBACK_EN`, read `BASE_ADDR+3` -> `spi_valid_o` one cycle later with data 0xA5. Without the macro -> `spi_valid_o` stays 0.
